// File: rtl/decode_issue_unit_l2_pkg.sv
// Shared ISA types for the decode/issue slice: micro-ops, immediate formats,
// per-pipe op subsets and the small decoder / immediate generator helpers.
package decode_issue_unit_l2_pkg;

  localparam int SEQ_W    = 8;
  localparam int NUM_UOPS = 9;

  typedef enum logic [3:0] {
    UOP_ADD, UOP_ADDI, UOP_MUL, UOP_LW, UOP_SW,
    UOP_JAL, UOP_JR, UOP_BNE, UOP_NONE
  } rv_uop;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_NONE} rv_imm_type;

  typedef logic [NUM_UOPS-1:0] rv_op_vec;

  localparam rv_op_vec p_tinyrv1 = 9'b0_1111_1111;

  typedef struct packed {
    logic       val;
    rv_uop      uop;
    logic       rs1_en;
    logic       rs2_en;
    logic       op2_sel;
    logic       wen;
    rv_imm_type imm_type;
  } dec_t;

  function automatic dec_t decode_inst(input logic [31:0] inst);
    dec_t d;
    d.val      = 1'b0;
    d.uop      = UOP_NONE;
    d.rs1_en   = 1'b0;
    d.rs2_en   = 1'b0;
    d.op2_sel  = 1'b0;
    d.wen      = 1'b0;
    d.imm_type = IMM_NONE;
    case (inst[6:0])
      7'b0110011: begin
        if (inst[14:12] == 3'b000 && (inst[31:25] == 7'd0 || inst[31:25] == 7'd1)) begin
          d.val    = 1'b1;
          d.uop    = (inst[25]) ? UOP_MUL : UOP_ADD;
          d.rs1_en = 1'b1;
          d.rs2_en = 1'b1;
          d.wen    = 1'b1;
        end
      end
      7'b0010011: begin
        if (inst[14:12] == 3'b000) begin
          d = '{1'b1, UOP_ADDI, 1'b1, 1'b0, 1'b1, 1'b1, IMM_I};
        end
      end
      7'b0000011: begin
        if (inst[14:12] == 3'b010) begin
          d = '{1'b1, UOP_LW, 1'b1, 1'b0, 1'b1, 1'b1, IMM_I};
        end
      end
      // Stores carry the offset in op2; rs2 is still tracked for hazards
      7'b0100011: begin
        if (inst[14:12] == 3'b010) begin
          d = '{1'b1, UOP_SW, 1'b1, 1'b1, 1'b1, 1'b0, IMM_S};
        end
      end
      7'b1101111: d = '{1'b1, UOP_JAL, 1'b0, 1'b0, 1'b1, 1'b1, IMM_J};
      7'b1100111: begin
        if (inst[14:12] == 3'b000) begin
          d = '{1'b1, UOP_JR, 1'b1, 1'b0, 1'b1, 1'b1, IMM_I};
        end
      end
      7'b1100011: begin
        if (inst[14:12] == 3'b001) begin
          d = '{1'b1, UOP_BNE, 1'b1, 1'b1, 1'b0, 1'b0, IMM_B};
        end
      end
      default: d.val = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input rv_imm_type t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_issue_unit_l2_inst_buffer.sv
// Circular instruction FIFO between fetch and decode; depth must be a power of 2
// so the pointers wrap naturally.
module decode_inst_buffer #(
  parameter int p_depth = 4,
  parameter int p_width = 72
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_val,
  output logic                         enq_rdy,
  input  logic [p_width-1:0]           enq_data,
  output logic                         deq_val,
  input  logic                         deq_rdy,
  output logic [p_width-1:0]           deq_data,
  output logic [$clog2(p_depth+1)-1:0] count
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = $clog2(p_depth+1);

  logic [p_width-1:0] mem [p_depth];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic               enq_xfer;
  logic               deq_xfer;

  // No pass-through: a full buffer refuses fetch even when the head issues
  assign enq_rdy  = (count != CW'(p_depth));
  assign deq_val  = (count != '0);
  assign enq_xfer = enq_val & enq_rdy;
  assign deq_xfer = deq_val & deq_rdy;
  assign deq_data = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_xfer) tail <= tail + 1'b1;
      if (deq_xfer) head <= head + 1'b1;
      if (enq_xfer && !deq_xfer) begin
        count <= count + 1'b1;
      end else if (!enq_xfer && deq_xfer) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq_xfer) mem[tail] <= enq_data;
  end

endmodule

// File: rtl/decode_issue_unit_l2.sv
// In-order single-issue decode/issue stage with an instruction buffer, a
// pending-write scoreboard and same-cycle completion bypass.
module decode_issue_unit_l2
  import decode_issue_unit_l2_pkg::*;
#(
  parameter int                         p_num_pipes    = 1,
  parameter rv_op_vec [p_num_pipes-1:0] p_pipe_subsets = {p_num_pipes{p_tinyrv1}},
  parameter int                         p_buf_depth    = 4,
  parameter bit                         p_bypass       = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_val,
  output logic                   f_rdy,
  input  logic [31:0]            f_inst,
  input  logic [31:0]            f_pc,
  input  logic [SEQ_W-1:0]       f_seq_num,
  output logic [p_num_pipes-1:0] ex_val,
  input  logic [p_num_pipes-1:0] ex_rdy,
  output logic [31:0]            ex_pc,
  output logic [31:0]            ex_op1,
  output logic [31:0]            ex_op2,
  output rv_uop                  ex_uop,
  output logic [4:0]             ex_waddr,
  output logic [SEQ_W-1:0]       ex_seq_num,
  input  logic                   complete_val,
  input  logic                   complete_wen,
  input  logic [4:0]             complete_waddr,
  input  logic [31:0]            complete_wdata,
  input  logic [SEQ_W-1:0]       complete_seq_num,
  output logic                   illegal
);

  typedef struct packed {
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [SEQ_W-1:0] seq_num;
  } buf_entry_t;

  localparam int EW = $bits(buf_entry_t);

  buf_entry_t                       enq_entry;
  buf_entry_t                       head;
  logic [EW-1:0]                    head_bits;
  logic                             head_val;
  logic [$clog2(p_buf_depth+1)-1:0] buf_count;
  logic                             x_xfer;
  dec_t                             dec;
  logic [31:0]                      imm;
  logic [4:0]                       raddr0, raddr1, waddr;
  logic [31:0]                      rf [32];
  logic [31:0]                      pending;
  logic [31:0]                      rdata0, rdata1, operand0, operand1;
  logic                             comp_wr, hit0, hit1, pend0, pend1, stall0, stall1;
  logic                             issue_val, illegal_q, illegal_now, found;
  logic [p_num_pipes-1:0]           route_sel;
  logic                             unused;

  assign enq_entry = '{inst: f_inst, pc: f_pc, seq_num: f_seq_num};
  assign head      = buf_entry_t'(head_bits);
  assign unused    = ^{complete_seq_num, buf_count};

  decode_inst_buffer #(
    .p_depth (p_buf_depth),
    .p_width (EW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .enq_val  (f_val),
    .enq_rdy  (f_rdy),
    .enq_data (enq_entry),
    .deq_val  (head_val),
    .deq_rdy  (x_xfer),
    .deq_data (head_bits),
    .count    (buf_count)
  );

  assign dec    = decode_inst(head.inst);
  assign imm    = gen_imm(head.inst, dec.imm_type);
  assign raddr0 = head.inst[19:15];
  assign raddr1 = head.inst[24:20];
  assign waddr  = head.inst[11:7];

  assign comp_wr = complete_val & complete_wen;
  assign rdata0  = (raddr0 == 5'd0) ? 32'd0 : rf[raddr0];
  assign rdata1  = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
  assign hit0    = comp_wr && (complete_waddr == raddr0) && (raddr0 != 5'd0);
  assign hit1    = comp_wr && (complete_waddr == raddr1) && (raddr1 != 5'd0);
  assign pend0   = dec.rs1_en & pending[raddr0];
  assign pend1   = dec.rs2_en & pending[raddr1];

  // Without bypass a dependent waits one cycle for the regfile write to land
  always_comb begin
    operand0 = rdata0;
    operand1 = rdata1;
    stall0   = pend0;
    stall1   = pend1;
    if (p_bypass) begin
      operand0 = hit0 ? complete_wdata : rdata0;
      operand1 = hit1 ? complete_wdata : rdata1;
      stall0   = pend0 & !hit0;
      stall1   = pend1 & !hit1;
    end
  end

  // First pipe whose op subset accepts the micro-op takes the instruction
  always_comb begin
    route_sel = '0;
    found     = 1'b0;
    for (int k = 0; k < p_num_pipes; k++) begin
      if (!found && p_pipe_subsets[k][dec.uop]) begin
        route_sel[k] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign issue_val  = !rst & head_val & dec.val & !stall0 & !stall1;
  assign ex_val     = issue_val ? route_sel : '0;
  assign x_xfer     = |(ex_val & ex_rdy);
  assign ex_pc      = head.pc;
  assign ex_seq_num = head.seq_num;
  assign ex_uop     = dec.uop;
  assign ex_waddr   = waddr;
  assign ex_op1     = operand0;
  assign ex_op2     = dec.op2_sel ? imm : operand1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf <= '{default: '0};
    end else if (comp_wr && complete_waddr != 5'd0) begin
      rf[complete_waddr] <= complete_wdata;
    end
  end

  // The later set overrides a same-cycle clear: the new producer is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (comp_wr) pending[complete_waddr] <= 1'b0;
      if (x_xfer && dec.wen && waddr != 5'd0) pending[waddr] <= 1'b1;
    end
  end

  assign illegal_now = !rst & head_val & !dec.val;
  assign illegal     = illegal_q | illegal_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (illegal_now) begin
      illegal_q <= 1'b1;
    end
  end

endmodule
